mem_bus_ctrl: RTL and testbench

Memory-access stage of the five-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. For non-memory instructions it passes the EX/MEM payload through combinationally. For loads and stores it runs a multi-cycle request/acknowledge transaction on the data bus, holds the pipeline through `stallreq` until the data is back, and returns sign- or zero-extended load data on the writeback path.

---
 rtl/mem_bus_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_bus_ctrl                                                  |
// | Purpose  : MEM stage - passes EX/MEM payload through, runs req/ack data  |
// |            bus transactions for loads/stores and stalls the pipeline.    |
// | Option   : MEM_BUS_TIMEOUT_EN - abandon a bus access after 16 idle cycles|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module mem_bus_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_hi,
  input  logic [31:0] mem_lo,
  input  logic        mem_whilo,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  output logic        stallreq,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        misalign_o
);

  localparam logic [7:0] c_op_lb  = 8'hE0;
  localparam logic [7:0] c_op_lbu = 8'hE4;
  localparam logic [7:0] c_op_lh  = 8'hE1;
  localparam logic [7:0] c_op_lhu = 8'hE5;
  localparam logic [7:0] c_op_lw  = 8'hE3;
  localparam logic [7:0] c_op_sb  = 8'hE8;
  localparam logic [7:0] c_op_sh  = 8'hE9;
  localparam logic [7:0] c_op_sw  = 8'hEB;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state, w_next;
  logic        r_bus_req, r_bus_we;
  logic [31:0] r_bus_addr, r_bus_wdata, r_data;
  logic [3:0]  r_bus_sel;
  logic [7:0]  r_aluop;
  logic [1:0]  r_lane;

  logic        w_is_load, w_is_store, w_is_mem, w_misalign, w_issue;
  logic [3:0]  w_sel, w_byte_sel;
  logic [31:0] w_st_data, w_load_val;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_timeout, w_to_err, w_to_pulse;
  logic        w_unused;

  // Only the MEM hold bit matters to this stage.
  assign w_unused = ^{stall[5], stall[3:0]};

  always_comb begin
    case (mem_mem_addr[1:0])
      2'd0:    w_byte_sel = 4'b1000;
      2'd1:    w_byte_sel = 4'b0100;
      2'd2:    w_byte_sel = 4'b0010;
      default: w_byte_sel = 4'b0001;
    endcase
  end

  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_misalign = 1'b0;
    w_sel      = 4'b0000;
    w_st_data  = mem_reg2;
    case (mem_aluop)
      c_op_lb, c_op_lbu: begin
        w_is_load = 1'b1;
        w_sel     = w_byte_sel;
      end
      c_op_lh, c_op_lhu: begin
        w_is_load  = 1'b1;
        w_misalign = mem_mem_addr[0];
        w_sel      = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
      end
      c_op_lw: begin
        w_is_load  = 1'b1;
        w_misalign = |mem_mem_addr[1:0];
        w_sel      = 4'b1111;
      end
      c_op_sb: begin
        w_is_store = 1'b1;
        w_sel      = w_byte_sel;
        w_st_data  = {4{mem_reg2[7:0]}};
      end
      c_op_sh: begin
        w_is_store = 1'b1;
        w_misalign = mem_mem_addr[0];
        w_sel      = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
        w_st_data  = {2{mem_reg2[15:0]}};
      end
      c_op_sw: begin
        w_is_store = 1'b1;
        w_misalign = |mem_mem_addr[1:0];
        w_sel      = 4'b1111;
      end
      default: ;
    endcase
  end

  assign w_is_mem = w_is_load | w_is_store;
  assign w_issue  = w_is_mem & ~w_misalign;

`ifdef MEM_BUS_TIMEOUT_EN
  logic [3:0] r_to_cnt;
  logic       r_to_flag, r_to_pulse;

  assign w_timeout  = (r_state == S_BUSY) && !bus_ack && (r_to_cnt == 4'hF);
  assign w_to_err   = r_to_flag;
  assign w_to_pulse = r_to_pulse;

  // r_to_flag marks the whole DONE visit as failed; r_to_pulse is the one-cycle error strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt   <= 4'h0;
      r_to_flag  <= 1'b0;
      r_to_pulse <= 1'b0;
    end else begin
      r_to_cnt   <= (r_state == S_BUSY) ? r_to_cnt + 4'h1 : 4'h0;
      r_to_pulse <= w_timeout;
      if (w_timeout)
        r_to_flag <= 1'b1;
      else if (r_state == S_DONE && w_next == S_IDLE)
        r_to_flag <= 1'b0;
    end
  end
`else
  assign w_timeout  = 1'b0;
  assign w_to_err   = 1'b0;
  assign w_to_pulse = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_next = S_BUSY;
      S_BUSY:  if (bus_ack || w_timeout) w_next = S_DONE;
      S_DONE:  if (!stall[4]) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'h0;
      r_bus_sel   <= 4'h0;
      r_bus_wdata <= 32'h0;
      r_data      <= 32'h0;
      r_aluop     <= 8'h0;
      r_lane      <= 2'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_issue) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= w_is_store;
        r_bus_addr  <= {mem_mem_addr[31:2], 2'b00};
        r_bus_sel   <= w_sel;
        r_bus_wdata <= w_st_data;
        r_aluop     <= mem_aluop;
        r_lane      <= mem_mem_addr[1:0];
      end else if (r_state == S_BUSY && (bus_ack || w_timeout)) begin
        r_bus_req <= 1'b0;
        if (w_timeout)
          r_data <= 32'h0;
        else if (!r_bus_we)
          r_data <= bus_rdata;
      end
    end
  end

  // Big-endian lane extraction from the captured word.
  always_comb begin
    case (r_lane)
      2'd0:    w_byte = r_data[31:24];
      2'd1:    w_byte = r_data[23:16];
      2'd2:    w_byte = r_data[15:8];
      default: w_byte = r_data[7:0];
    endcase
    w_half = r_lane[1] ? r_data[15:0] : r_data[31:16];
    case (r_aluop)
      c_op_lb:  w_load_val = {{24{w_byte[7]}}, w_byte};
      c_op_lbu: w_load_val = {24'h0, w_byte};
      c_op_lh:  w_load_val = {{16{w_half[15]}}, w_half};
      c_op_lhu: w_load_val = {16'h0, w_half};
      default:  w_load_val = r_data;
    endcase
  end

  always_comb begin
    wd_o       = mem_wd;
    wreg_o     = mem_wreg;
    wdata_o    = mem_wdata;
    hi_o       = mem_hi;
    lo_o       = mem_lo;
    whilo_o    = mem_whilo;
    stallreq   = 1'b0;
    misalign_o = 1'b0;
    if (!rst) begin
      wd_o    = 5'd0;
      wreg_o  = 1'b0;
      wdata_o = 32'h0;
      hi_o    = 32'h0;
      lo_o    = 32'h0;
      whilo_o = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_mem && w_misalign) begin
            misalign_o = 1'b1;
            wreg_o     = 1'b0;
          end else if (w_is_mem) begin
            stallreq = 1'b1;
          end
        end
        S_BUSY: stallreq = 1'b1;
        S_DONE: begin
          if (!r_bus_we)
            wdata_o = w_load_val;
          if (w_to_err)
            wreg_o = 1'b0;
          misalign_o = w_to_pulse;
        end
        default: ;
      endcase
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_sel   = r_bus_sel;
  assign bus_wdata = r_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// Self-checking bench for mem_bus_ctrl: scoreboard of expected writeback results
// popped when the stage reaches its completion cycle.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = 6'b0;
  logic [4:0]  mem_wd = 5'd9;
  logic        mem_wreg = 1'b1;
  logic [31:0] mem_wdata = 32'h1111_2222;
  logic [31:0] mem_hi = 32'h3333_4444;
  logic [31:0] mem_lo = 32'h5555_6666;
  logic        mem_whilo = 1'b1;
  logic [7:0]  mem_aluop = 8'hE3;
  logic [31:0] mem_mem_addr = 32'h100;
  logic [31:0] mem_reg2 = 32'h0;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, stallreq, bus_req, bus_we, misalign_o;
  logic [31:0] wdata_o, hi_o, lo_o, bus_addr, bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ack = 1'b0;

  localparam logic [31:0] c_pass = 32'h5555_AAAA;

  typedef struct {
    logic [31:0] wdata;
    logic        wreg;
    logic        mis;
    int          busy;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] bwdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  mem_bus_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o),
    .whilo_o(whilo_o), .stallreq(stallreq),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] op, input logic [31:0] addr,
                                 input logic [31:0] st, input logic [31:0] rdata,
                                 input int wait_cyc, input logic wreg);
    exp_t        e;
    logic [31:0] sh;
    logic [3:0]  one;
    int          nb;
    bit          is_load;
    one      = 4'b0001;
    nb       = 3 - int'(addr[1:0]);
    is_load  = (op[3] == 1'b0);
    e.wdata  = c_pass;
    e.wreg   = wreg;
    e.mis    = 1'b0;
    e.busy   = (wait_cyc < 0) ? 16 : wait_cyc + 1;
    e.we     = op[3];
    e.addr   = {addr[31:2], 2'b00};
    e.sel    = 4'hF;
    e.bwdata = st;
    case (op)
      8'hE0, 8'hE4, 8'hE8: begin
        e.sel    = one << nb;
        sh       = rdata >> (8 * nb);
        e.bwdata = {4{st[7:0]}};
        if (op == 8'hE0) e.wdata = {{24{sh[7]}}, sh[7:0]};
        if (op == 8'hE4) e.wdata = {24'h0, sh[7:0]};
      end
      8'hE1, 8'hE5, 8'hE9: begin
        e.sel    = addr[1] ? 4'b0011 : 4'b1100;
        sh       = addr[1] ? rdata : (rdata >> 16);
        e.bwdata = {2{st[15:0]}};
        if (op == 8'hE1) e.wdata = {{16{sh[15]}}, sh[15:0]};
        if (op == 8'hE5) e.wdata = {16'h0, sh[15:0]};
      end
      default: if (is_load) e.wdata = rdata;
    endcase
    if (wait_cyc < 0) begin
      e.wdata = is_load ? 32'h0 : c_pass;
      e.wreg  = 1'b0;
      e.mis   = 1'b1;
    end
    return e;
  endfunction

  task automatic drive_nop();
    mem_aluop    = 8'h21;
    mem_wd       = 5'd3;
    mem_wreg     = 1'b1;
    mem_wdata    = c_pass;
    mem_mem_addr = 32'h0;
  endtask

  task automatic run_op(input string name, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] st, input logic wreg, input int wait_cyc,
                        input logic [31:0] rdata, input bit hold);
    exp_t        e, got;
    int          busy = 0;
    int          stl = 0;
    bit          done = 0;
    logic [31:0] held;
    @(negedge clk);
    mem_aluop = op; mem_mem_addr = addr; mem_reg2 = st; mem_wreg = wreg;
    mem_wd = 5'd7; mem_wdata = c_pass; stall = 6'b0; bus_ack = 1'b0;
    sb.push_back(model(op, addr, st, rdata, wait_cyc, wreg));
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      #1;
      if (stallreq) stl++;
      if (bus_req) begin
        busy++;
        if (busy == 1) begin
          e = sb[0];
          check({name, "_sel"}, bus_sel, e.sel);
          check({name, "_addr"}, bus_addr, e.addr);
          check({name, "_we"}, bus_we, e.we);
          if (e.we) check({name, "_bwdata"}, bus_wdata, e.bwdata);
        end
        bus_ack   = (wait_cyc >= 0) && (busy == wait_cyc + 1);
        bus_rdata = rdata;
      end else if (stl > 0 && !stallreq) begin
        bus_ack = 1'b0;
        got = sb.pop_front();
        check({name, "_wdata"}, wdata_o, got.wdata);
        check({name, "_wreg"}, wreg_o, got.wreg);
        check({name, "_mis"}, misalign_o, got.mis);
        check({name, "_busy"}, busy, got.busy);
        check({name, "_stallcyc"}, stl, got.busy + 1);
        if (hold) begin
          held = wdata_o;
          stall[4] = 1'b1;
          for (int h = 0; h < 2; h++) begin
            @(negedge clk); #1;
            check({name, "_hold_req"}, bus_req, 1'b0);
            check({name, "_hold_stall"}, stallreq, 1'b0);
            check({name, "_hold_wdata"}, wdata_o, held);
            check({name, "_hold_mis"}, misalign_o, 1'b0);
          end
          stall[4] = 1'b0;
        end
        done = 1;
      end
      @(negedge clk);
    end
    if (!done) begin
      check({name, "_no_completion"}, 32'd0, 32'd1);
      sb.delete();
    end
    bus_ack = 1'b0;
    drive_nop();
    #1;
    check({name, "_no_reissue"}, bus_req, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state with non-zero inputs applied
    #3;
    check("rst_wd", wd_o, 5'd0);
    check("rst_wreg", wreg_o, 1'b0);
    check("rst_wdata", wdata_o, 32'h0);
    check("rst_hi", hi_o, 32'h0);
    check("rst_lo", lo_o, 32'h0);
    check("rst_stallreq", stallreq, 1'b0);
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_bus_sel", bus_sel, 4'h0);
    check("rst_mis", misalign_o, 1'b0);
    @(negedge clk);
    drive_nop();
    rst = 1'b1;

    // Non-memory passthrough
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_aluop = 8'h21 + 8'(i); mem_wd = 5'($urandom); mem_wreg = 1'($urandom);
      mem_wdata = $urandom; mem_hi = $urandom; mem_lo = $urandom; mem_whilo = 1'($urandom);
      #1;
      check("pt_wd", wd_o, mem_wd);
      check("pt_wreg", wreg_o, mem_wreg);
      check("pt_wdata", wdata_o, mem_wdata);
      check("pt_hi", hi_o, mem_hi);
      check("pt_lo", lo_o, mem_lo);
      check("pt_whilo", whilo_o, mem_whilo);
      check("pt_stall", stallreq, 1'b0);
    end
    @(negedge clk);
    drive_nop();

    run_op("lw",  8'hE3, 32'h100, 32'h0, 1'b1, 1, 32'hDEADBEEF, 0);
    run_op("lb",  8'hE0, 32'h103, 32'h0, 1'b1, 0, 32'h123456F0, 0);
    run_op("lbu", 8'hE4, 32'h103, 32'h0, 1'b1, 2, 32'h123456F0, 0);
    run_op("lb0", 8'hE0, 32'h100, 32'h0, 1'b1, 0, 32'h8A345678, 0);
    run_op("lh",  8'hE1, 32'h102, 32'h0, 1'b1, 0, 32'h12348765, 0);
    run_op("lhu", 8'hE5, 32'h100, 32'h0, 1'b1, 1, 32'h87651234, 0);
    run_op("sh",  8'hE9, 32'h202, 32'h0000ABCD, 1'b0, 0, 32'h0, 0);
    run_op("sb",  8'hE8, 32'h001, 32'h00000011, 1'b0, 3, 32'h0, 0);
    run_op("sw",  8'hEB, 32'h300, 32'hCAFEF00D, 1'b0, 0, 32'h0, 0);
    run_op("lwh", 8'hE3, 32'h104, 32'h0, 1'b1, 0, 32'h0BADCAFE, 1);

    // Misaligned accesses never reach the bus
    @(negedge clk);
    mem_aluop = 8'hE3; mem_mem_addr = 32'h101; mem_wreg = 1'b1; mem_wdata = c_pass;
    #1;
    check("mis_lw_flag", misalign_o, 1'b1);
    check("mis_lw_wreg", wreg_o, 1'b0);
    check("mis_lw_stall", stallreq, 1'b0);
    @(negedge clk); #1;
    check("mis_lw_req", bus_req, 1'b0);
    mem_aluop = 8'hE9; mem_mem_addr = 32'h203;
    #1;
    check("mis_sh_flag", misalign_o, 1'b1);
    @(negedge clk); #1;
    check("mis_sh_req", bus_req, 1'b0);
    drive_nop();
    #1;
    check("mis_clear", misalign_o, 1'b0);

    // Reset in the middle of a transaction
    @(negedge clk);
    mem_aluop = 8'hE3; mem_mem_addr = 32'h400; mem_wreg = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rstmid_req_before", bus_req, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    check("rstmid_req", bus_req, 1'b0);
    check("rstmid_stall", stallreq, 1'b0);
    check("rstmid_wreg", wreg_o, 1'b0);
    check("rstmid_wdata", wdata_o, 32'h0);
    check("rstmid_wd", wd_o, 5'd0);
    @(negedge clk);
    drive_nop();
    rst = 1'b1;
    bus_ack = 1'b1;
    bus_rdata = 32'hFFFF0000;
    @(negedge clk); #1;
    check("late_ack_req", bus_req, 1'b0);
    check("late_ack_stall", stallreq, 1'b0);
    check("late_ack_wdata", wdata_o, c_pass);
    bus_ack = 1'b0;
    run_op("lw2", 8'hE3, 32'h500, 32'h0, 1'b1, 0, 32'h13579BDF, 0);

`ifdef MEM_BUS_TIMEOUT_EN
    run_op("lw_to", 8'hE3, 32'h600, 32'h0, 1'b1, -1, 32'h0, 1);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
